core_ctrl: RTL and testbench

- Instruction sequencer for `core`. Generates the 34-bit `inst` word cycle by cycle to run one full convolution pass over KIJ kernel positions.
- Per position, four phases in order:
  1. Weight fetch from the weight/input SRAM into L0.
  2. Kernel load into the MAC array.
  3. Activation fetch into L0, then execute.
  4. OFIFO drain into the psum SRAM.
- Sits between the testbench/host `start` handshake and `core.inst`. Observes `core.ofifo_valid` for drain flow control.

---
 rtl/core_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl
// Purpose  : Instruction sequencer for `core`. It emits the 34-bit inst word
//            cycle by cycle for one convolution pass over KIJ kernel
//            positions. Each position runs these phases in order:
//            weight fetch, kernel load, gap, activation fetch, execute,
//            OFIFO drain.
// Ports    : clk          - clock
//            reset        - asynchronous active-low reset
//            start        - pulse; begins a pass when idle
//            abort        - synchronous; returns to IDLE on the next cycle
//            ofifo_valid  - OFIFO in core holds a word
//            inst[33:0]   - instruction word to core (registered)
//            busy         - pass in progress (registered)
//            done         - one-cycle end-of-pass pulse (registered)
//            kij_idx[3:0] - current kernel position (registered)
//            perf_stall   - DRAIN cycles with ofifo_valid low, saturating
//                           (present only when CORE_CTRL_PERF_EN is defined)
// Options  : CORE_CTRL_PERF_EN - adds the perf_stall counter and port
// Revision : 1.0 - initial release
// ============================================================================
module core_ctrl #(
  parameter int          ROW       = 8,
  parameter int          COL       = 8,
  parameter int          KIJ       = 9,
  parameter int          NACT      = 36,
  parameter logic [10:0] WGT_BASE  = 11'h400,
  parameter logic [10:0] ACT_BASE  = 11'h000,
  parameter logic [10:0] PSUM_BASE = 11'h000,
  parameter int          GAP       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [15:0] perf_stall
`endif
);

  // Phase counter covers the longest phase.
  localparam int c_M1  = (COL > GAP) ? COL : GAP;
  localparam int c_M2  = (c_M1 > ROW) ? c_M1 : ROW;
  localparam int c_MAX = (c_M2 > NACT) ? c_M2 : NACT;
  localparam int c_CW  = $clog2(c_MAX + 1);

  localparam logic [33:0] c_IDLE_WORD = 34'h1800C0000;

  // inst bit positions
  localparam int c_ACC      = 33;
  localparam int c_CEN_P    = 32;
  localparam int c_WEN_P    = 31;
  localparam int c_CEN_X    = 19;
  localparam int c_OFIFO_RD = 6;
  localparam int c_L0_RD    = 3;
  localparam int c_L0_WR    = 2;
  localparam int c_EXEC     = 1;
  localparam int c_LOAD     = 0;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WLD   = 4'd1,
    S_WKRN  = 4'd2,
    S_WGAP  = 4'd3,
    S_ALD   = 4'd4,
    S_EXE   = 4'd5,
    S_DRAIN = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_k;
  logic [c_CW-1:0] r_rd;     // OFIFO reads issued this position
  logic [c_CW-1:0] r_m;      // pmem writes issued this position
  logic [33:0]     r_inst;
  logic            r_busy;
  logic            r_done;

  state_t          w_state_nx;
  logic [c_CW-1:0] w_cnt_nx;
  logic [3:0]      w_k_nx;
  logic [c_CW-1:0] w_rd_nx;
  logic [c_CW-1:0] w_m_nx;
  logic            w_ofrd_nx;
  logic            w_pwr_nx;
  logic [33:0]     w_inst_nx;
  logic            w_accept;

  assign w_accept = (r_state == S_IDLE) && start && !abort;

  // Next state and counters
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_k_nx     = r_k;
    w_rd_nx    = r_rd;
    w_m_nx     = r_m;
    w_ofrd_nx  = 1'b0;
    w_pwr_nx   = 1'b0;
    if (abort) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nx = S_WLD;
            w_k_nx     = 4'd0;
            w_cnt_nx   = '0;
          end
        end
        S_WLD: begin
          if (r_cnt == c_CW'(COL - 1)) begin
            w_state_nx = S_WKRN;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + c_CW'(1);
          end
        end
        S_WKRN: begin
          if (r_cnt == c_CW'(COL - 1)) begin
            w_state_nx = S_WGAP;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + c_CW'(1);
          end
        end
        S_WGAP: begin
          if (r_cnt == c_CW'(GAP - 1)) begin
            w_state_nx = S_ALD;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + c_CW'(1);
          end
        end
        S_ALD: begin
          if (r_cnt == c_CW'(NACT - 1)) begin
            w_state_nx = S_EXE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + c_CW'(1);
          end
        end
        S_EXE: begin
          if (r_cnt == c_CW'(NACT - 1)) begin
            w_state_nx = S_DRAIN;
            w_cnt_nx   = '0;
            w_rd_nx    = '0;
            w_m_nx     = '0;
          end else begin
            w_cnt_nx = r_cnt + c_CW'(1);
          end
        end
        S_DRAIN: begin
          // r_m reaching NACT means the last write is on inst this cycle.
          if (r_m == c_CW'(NACT)) begin
            w_state_nx = S_NEXT;
          end else begin
            if (ofifo_valid && (r_rd != c_CW'(NACT))) begin
              w_ofrd_nx = 1'b1;
              w_rd_nx   = r_rd + c_CW'(1);
            end
            // The word popped last cycle is written this cycle.
            if (r_inst[c_OFIFO_RD]) begin
              w_pwr_nx = 1'b1;
              w_m_nx   = r_m + c_CW'(1);
            end
          end
        end
        S_NEXT: begin
          if (r_k == 4'(KIJ - 1)) begin
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_WLD;
            w_k_nx     = r_k + 4'd1;
            w_cnt_nx   = '0;
          end
        end
        S_DONE:  w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Next instruction word, built from the upcoming state
  always_comb begin
    w_inst_nx = c_IDLE_WORD;
    // Read data lands one cycle after an xmem read; abort drops it.
    if (w_state_nx != S_IDLE) begin
      w_inst_nx[c_L0_WR] = ~r_inst[c_CEN_X];
    end
    case (w_state_nx)
      S_WLD: begin
        w_inst_nx[c_CEN_X] = 1'b0;
        w_inst_nx[17:7]    = WGT_BASE + 11'(w_k_nx) * 11'(COL) + 11'(w_cnt_nx);
      end
      S_WKRN: begin
        w_inst_nx[c_L0_RD] = 1'b1;
        w_inst_nx[c_LOAD]  = 1'b1;
      end
      S_ALD: begin
        w_inst_nx[c_CEN_X] = 1'b0;
        w_inst_nx[17:7]    = ACT_BASE + 11'(w_cnt_nx);
      end
      S_EXE: begin
        w_inst_nx[c_L0_RD] = 1'b1;
        w_inst_nx[c_EXEC]  = 1'b1;
      end
      S_DRAIN: begin
        w_inst_nx[c_OFIFO_RD] = w_ofrd_nx;
        if (w_pwr_nx) begin
          w_inst_nx[c_CEN_P] = 1'b0;
          w_inst_nx[c_WEN_P] = 1'b0;
          w_inst_nx[30:20]   = PSUM_BASE + 11'(r_m);
          w_inst_nx[c_ACC]   = (r_k != 4'd0);
        end
      end
      default: ;
    endcase
  end

`ifdef CORE_CTRL_PERF_EN
  logic [15:0] r_perf;
  assign perf_stall = r_perf;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= 4'd0;
      r_rd    <= '0;
      r_m     <= '0;
      r_inst  <= c_IDLE_WORD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef CORE_CTRL_PERF_EN
      r_perf  <= 16'd0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_k     <= w_k_nx;
      r_rd    <= w_rd_nx;
      r_m     <= w_m_nx;
      r_inst  <= w_inst_nx;
      r_busy  <= (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
      r_done  <= (w_state_nx == S_DONE);
`ifdef CORE_CTRL_PERF_EN
      if (w_accept) begin
        r_perf <= 16'd0;
      end else if ((r_state == S_DRAIN) && !ofifo_valid && (r_perf != 16'hFFFF)) begin
        r_perf <= r_perf + 16'd1;
      end
`endif
    end
  end

  assign inst    = r_inst;
  assign busy    = r_busy;
  assign done    = r_done;
  assign kij_idx = r_k;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl
// Purpose  : Directed self-checking bench for core_ctrl. Walks every cycle
//            of each kernel position against hand-derived instruction words.
//            Covers full passes, drain stalls, abort, start-while-busy and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;
`ifdef CORE_CTRL_PERF_EN
  logic [15:0] perf_stall;
`endif

  int nerr = 0;
  int nchk = 0;
  int wr_total = 0;
  int done_total = 0;

  core_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx)
`ifdef CORE_CTRL_PERF_EN
    ,
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (!inst[32] && !inst[31]) wr_total++;
    if (done) done_total++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [33:0] IDLE = 34'h1800C0000;

  function automatic logic [33:0] mk(input bit acc, input bit cenp, input bit wenp,
                                     input logic [10:0] ap, input bit cenx, input bit wenx,
                                     input logic [10:0] ax, input logic [6:0] lo);
    return {acc, cenp, wenp, ap, cenx, wenx, ax, lo};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pat(input int mode, input int c);
    if (mode == 1) return (c % 2) == 0;
    if (mode == 2) return !(c == 3 || c == 5 || c == 7 || c == 9 || c == 11);
    return 1'b1;
  endfunction

  // Entered at the negedge of WLD cycle 0 of position k; leaves at the
  // negedge following the NEXT cycle unless stopped early.
  task automatic walk_pos(input int k, input int mode, input bit glitch,
                          input int abort_m, input int stop_exe, output bit early);
    logic [33:0] e;
    int rdcnt, m, c;
    bit rd_cur, wr_cur, rd_nx, v;
    early = 1'b0;
    chk("kij_idx", 34'(kij_idx), 34'(k));
    chk("busy", 34'(busy), 34'd1);
    for (int i = 0; i < 8; i++) begin
      e = mk(0, 1, 1, 11'h0, 0, 1, 11'(32'h400 + 8 * k + i), (i > 0) ? 7'h04 : 7'h00);
      chk("wld", inst, e);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk("wkrn", inst, mk(0, 1, 1, 11'h0, 1, 1, 11'h0, (i == 0) ? 7'h0D : 7'h09));
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      chk("wgap", inst, IDLE);
      start = glitch && (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    for (int j = 0; j < 36; j++) begin
      chk("ald", inst, mk(0, 1, 1, 11'h0, 0, 1, 11'(j), (j > 0) ? 7'h04 : 7'h00));
      @(negedge clk);
    end
    for (int j = 0; j < 36; j++) begin
      chk("exe", inst, mk(0, 1, 1, 11'h0, 1, 1, 11'h0, (j == 0) ? 7'h0E : 7'h0A));
      if (j == stop_exe) begin
        early = 1'b1;
        return;
      end
      start = glitch && (j == 5);
      @(negedge clk);
    end
    start  = 1'b0;
    rdcnt  = 0;
    m      = 0;
    rd_cur = 1'b0;
    wr_cur = 1'b0;
    c      = 0;
    while (1) begin
      if (c > 300) begin
        chk("drain_bound", 34'(c), 34'd0);
        early = 1'b1;
        return;
      end
      e = mk(wr_cur ? (k != 0) : 1'b0, !wr_cur, !wr_cur, wr_cur ? 11'(m) : 11'h0,
             1, 1, 11'h0, rd_cur ? 7'h40 : 7'h00);
      chk("drain", inst, e);
      if (wr_cur) m++;
      v = pat(mode, c);
      ofifo_valid = v;
      if (wr_cur && m == 36) break;
      if (wr_cur && m == abort_m) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_inst", inst, IDLE);
        chk("abort_busy", 34'(busy), 34'd0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("abort_quiet", inst, IDLE);
        end
        ofifo_valid = 1'b1;
        early = 1'b1;
        return;
      end
      rd_nx = v && (rdcnt < 36);
      if (rd_nx) rdcnt++;
      wr_cur = rd_cur;
      rd_cur = rd_nx;
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    ofifo_valid = 1'b1;
    chk("next_inst", inst, IDLE);
    chk("next_kij", 34'(kij_idx), 34'(k));
    chk("next_busy", 34'(busy), 34'd1);
    @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int  wr_base, done_base;
  bit  early;

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    ofifo_valid = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst", inst, IDLE);
    chk("rst_busy", 34'(busy), 34'd0);
    chk("rst_done", 34'(done), 34'd0);
    chk("rst_kij", 34'(kij_idx), 34'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_inst", inst, IDLE);

    // Pass 1: full pass, ofifo_valid tied high, start glitches while busy
    wr_base   = wr_total;
    done_base = done_total;
    pulse_start();
    for (int k = 0; k < 9; k++) walk_pos(k, 0, (k == 3) || (k == 5), -1, -1, early);
    chk("done_pulse", 34'(done), 34'd1);
    chk("done_busy", 34'(busy), 34'd0);
    chk("done_inst", inst, IDLE);
    chk("done_kij", 34'(kij_idx), 34'd8);
    @(negedge clk);
    chk("post_done", 34'(done), 34'd0);
    chk("post_busy", 34'(busy), 34'd0);
    chk("pass_writes", 34'(wr_total - wr_base), 34'd324);
    chk("pass_dones", 34'(done_total - done_base), 34'd1);

    // Pass 2: toggling drain in k=0,1; weight addresses at k=2; abort at m=10
    @(negedge clk);
    pulse_start();
    walk_pos(0, 1, 0, -1, -1, early);
    walk_pos(1, 1, 0, -1, -1, early);
    walk_pos(2, 0, 0, 10, -1, early);
    chk("abort_taken", 34'(early), 34'd1);

    // Pass 3: restart from k=0, five stalls in each of two positions
    wr_base   = wr_total;
    done_base = done_total;
    pulse_start();
    chk("restart_addr", 34'(inst[17:7]), 34'h400);
    walk_pos(0, 2, 0, -1, -1, early);
    walk_pos(1, 2, 0, -1, -1, early);
    for (int k = 2; k < 9; k++) walk_pos(k, 0, 0, -1, -1, early);
    chk("done2_pulse", 34'(done), 34'd1);
`ifdef CORE_CTRL_PERF_EN
    chk("perf_stall", 34'(perf_stall), 34'd10);
`endif
    @(negedge clk);
    chk("pass3_writes", 34'(wr_total - wr_base), 34'd324);

    // Pass 4: asynchronous reset mid-EXE at k=1
    @(negedge clk);
    pulse_start();
    walk_pos(0, 0, 0, -1, -1, early);
    walk_pos(1, 0, 0, -1, 20, early);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_inst", inst, IDLE);
    chk("arst_busy", 34'(busy), 34'd0);
    chk("arst_kij", 34'(kij_idx), 34'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_quiet", inst, IDLE);
    end
    chk("arst_busy2", 34'(busy), 34'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
